// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point datapath blocks: FSM encodings and
// two's-complement saturation limits.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Limits are returned 64 bits wide; callers narrow them to their own width.
    function automatic logic [63:0] max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_neg(input int w);
        return ~(64'd1 << (w - 1)) + 64'd1;
    endfunction

endpackage

// File: rtl/fixed_point_sat.sv
// Combinational saturation: unsigned double-width magnitude plus sign in,
// WIDTH-bit two's-complement value and overflow flag out.
module fixed_point_sat
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] mag,
    input  logic               sign,
    output logic [WIDTH-1:0]   value,
    output logic               overflow
);

    localparam logic [WIDTH-1:0]   MAX_VAL = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0]   MIN_VAL = WIDTH'(min_neg(WIDTH));
    localparam logic [2*WIDTH-1:0] POS_LIM = (2*WIDTH)'(max_pos(WIDTH));
    // Negative side reaches one further: |-2^(W-1)| = 2^(W-1).
    localparam logic [2*WIDTH-1:0] NEG_LIM = POS_LIM + (2*WIDTH)'(1);

    always_comb begin
        value    = '0;
        overflow = 1'b0;
        if (!sign) begin
            if (mag > POS_LIM) begin
                value    = MAX_VAL;
                overflow = 1'b1;
            end else begin
                value = mag[WIDTH-1:0];
            end
        end else begin
            if (mag > NEG_LIM) begin
                value    = MIN_VAL;
                overflow = 1'b1;
            end else begin
                value = ~mag[WIDTH-1:0] + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/fixed_point_mul.sv
// Iterative signed fixed-point multiplier: sign-magnitude shift-add, one
// multiplier bit per cycle, truncation toward zero and saturation on output.
module fixed_point_mul
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] VALUE_A_IN,
    input  logic [WIDTH-1:0] VALUE_B_IN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic [WIDTH-1:0] VALUE_OUT,
    output logic             OVERFLOW_OUT,
    output logic             VALID_OUT
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               sign;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mag_trunc;
    logic [WIDTH-1:0]   sat_value;
    logic               sat_ovf;
    logic               accept;
    logic               last_bit;

    assign accept    = VALID_IN && READY_OUT;
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    // Dropping the fractional bits of an unsigned magnitude rounds toward zero.
    assign mag_trunc = acc >> FRAC_BITS;

    fixed_point_sat #(.WIDTH(WIDTH)) u_sat (
        .mag      (mag_trunc),
        .sign     (sign),
        .value    (sat_value),
        .overflow (sat_ovf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        READY_OUT  = 1'b0;
        case (state)
            IDLE: begin
                READY_OUT = 1'b1;
                if (VALID_IN) state_next = BUSY;
            end
            BUSY:    if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt          <= '0;
            sign         <= 1'b0;
            mag_a        <= '0;
            mag_b        <= '0;
            acc          <= '0;
            VALUE_OUT    <= '0;
            OVERFLOW_OUT <= 1'b0;
            VALID_OUT    <= 1'b0;
        end else begin
            VALID_OUT <= (state == DONE);
            if (accept) begin
                sign  <= VALUE_A_IN[WIDTH-1] ^ VALUE_B_IN[WIDTH-1];
                mag_a <= VALUE_A_IN[WIDTH-1] ? (~VALUE_A_IN + WIDTH'(1)) : VALUE_A_IN;
                mag_b <= VALUE_B_IN[WIDTH-1] ? (~VALUE_B_IN + WIDTH'(1)) : VALUE_B_IN;
                acc   <= '0;
                cnt   <= '0;
            end
            if (state == BUSY) begin
                if (mag_b[cnt]) begin
                    acc <= acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
                end
                cnt <= last_bit ? '0 : cnt + CNT_W'(1);
            end
            if (state == DONE) begin
                VALUE_OUT    <= sat_value;
                OVERFLOW_OUT <= sat_ovf;
            end
        end
    end

endmodule
